sorted_move_reader: RTL and testbench

- Consumer end of the sorted move buffer.
- The buffer keeps key/value pairs in descending key order, with the head at index 0. This block drains the buffer one entry at a time, highest key first, and presents each entry downstream on a valid/ready handshake.
- It pulses the buffer's dequeue input once per entry it issues.
- It sits between move generation/scoring and the search engine. It supports an optional top-N limit and an abort/flush.

---
 rtl/sorted_move_reader_pkg.sv | 19 +
 rtl/sorted_move_reader_if.sv | 20 ++
 rtl/sorted_move_reader.sv | 106 ++++++++++
 tb/tb_sorted_move_reader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorted_move_reader_pkg.sv
// Shared types and default sizes for the sorted move buffer and its reader.
package sorter_pkg;

    localparam int DEF_MAX_LEN    = 32;
    localparam int DEF_KEY_BITS   = 8;
    localparam int DEF_VALUE_BITS = 15;

    typedef logic [DEF_VALUE_BITS-1:0] move_value_t;
    typedef logic [DEF_KEY_BITS-1:0]   move_key_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_DONE    = 3'd3,
        ST_FLUSH   = 3'd4
    } reader_state_t;

endpackage

// File: rtl/sorted_move_reader_if.sv
// Downstream move stream from the sorted move reader to the search engine.
interface sorted_move_reader_if
    import sorter_pkg::*;
#(
    parameter int KEY_BITS   = DEF_KEY_BITS,
    parameter int VALUE_BITS = DEF_VALUE_BITS
);
    logic [VALUE_BITS-1:0] value;
    logic [KEY_BITS-1:0]   key;
    logic                  valid;
    logic                  ready;
    logic                  last;

    // Handshake: an entry transfers on a clock edge where valid and ready are both high.
    // While valid is high and ready is low, value/key/last are held stable; valid never
    // drops without a transfer except on flush or reset. last is only meaningful with valid.
    modport master (output value, key, valid, last, input ready);
    modport slave  (input value, key, valid, last, output ready);

endinterface

// File: rtl/sorted_move_reader.sv
// Drains the descending-key move buffer one entry at a time, highest key first,
// with an optional top-N limit and an abort/flush that empties the buffer.
module sorted_move_reader
    import sorter_pkg::*;
#(
    parameter int  MAX_LEN    = DEF_MAX_LEN,
    parameter int  KEY_BITS   = DEF_KEY_BITS,
    parameter int  VALUE_BITS = DEF_VALUE_BITS,
    localparam int CW         = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [CW-1:0]         limit_in,
    input  logic                  flush_in,
    input  logic [VALUE_BITS-1:0] head_value_in,
    input  logic [KEY_BITS-1:0]   head_key_in,
    input  logic [CW-1:0]         len_in,
    output logic                  dequeue_out,
    sorted_move_reader_if.master  out_if,
    output logic [CW-1:0]         issued_count_out,
    output logic                  busy_out,
    output logic                  done_out,
    output reader_state_t         state_out
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    reader_state_t state;
    reader_state_t state_nxt;
    logic [CW-1:0] limit_q;
    logic [CW-1:0] count_plus1;
    logic          hit_limit;
    logic          is_last;
    logic          accept;
    logic          flush_go;

    assign count_plus1 = issued_count_out + CW'(1);
    assign hit_limit   = (limit_q != '0) && (count_plus1 == limit_q);
    // In PRESENT the buffer has already popped this entry, so len_in==0 means it was the tail.
    assign is_last     = (len_in == '0) || hit_limit;
    assign accept      = out_if.valid && out_if.ready;
    assign flush_go    = flush_in && ((state != ST_IDLE) || (len_in != '0));

    assign out_if.last = out_if.valid && is_last;
    assign busy_out    = (state != ST_IDLE);
    assign state_out   = state;

    always_comb begin
        state_nxt = state;
        if (flush_go) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) state_nxt = (len_in == '0) ? ST_DONE : ST_FETCH;
                end
                ST_FETCH:   state_nxt = ST_PRESENT;
                ST_PRESENT: begin
                    if (accept) state_nxt = is_last ? ST_DONE : ST_FETCH;
                end
                ST_DONE:    state_nxt = ST_IDLE;
                ST_FLUSH: begin
                    if ((len_in == '0) && !dequeue_out) state_nxt = ST_IDLE;
                end
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= ST_IDLE;
            limit_q          <= '0;
            issued_count_out <= '0;
            dequeue_out      <= 1'b0;
            done_out         <= 1'b0;
            out_if.valid     <= 1'b0;
            out_if.value     <= '0;
            out_if.key       <= '0;
        end else begin
            state        <= state_nxt;
            out_if.valid <= (state_nxt == ST_PRESENT);
            done_out     <= (state_nxt == ST_DONE);
            // A strobe still high this cycle pops one more entry at this edge, so only keep
            // flushing while something would remain after it.
            dequeue_out  <= (state_nxt == ST_FETCH) ||
                            ((state_nxt == ST_FLUSH) && (len_in > CW'(dequeue_out)));

            if (state == ST_FETCH) begin
                out_if.value <= head_value_in;
                out_if.key   <= head_key_in;
            end

            if ((state == ST_IDLE) && start_in && !flush_go) begin
                issued_count_out <= '0;
                if (len_in != '0) limit_q <= limit_in;
            end

            if ((state == ST_PRESENT) && accept && !flush_go && (issued_count_out != MAX_CNT)) begin
                issued_count_out <= count_plus1;
            end
        end
    end

endmodule

// File: tb/tb_sorted_move_reader.sv
// Scoreboard bench for sorted_move_reader against a queue model of the sorted move buffer.
module tb_sorted_move_reader;
    import sorter_pkg::*;

    localparam int MAX_LEN    = 32;
    localparam int KEY_BITS   = 8;
    localparam int VALUE_BITS = 15;
    localparam int CW         = $clog2(MAX_LEN + 1);
    localparam int W          = KEY_BITS + VALUE_BITS + 1;

    logic                  clk_in;
    logic                  rst_in;
    logic                  start_in;
    logic [CW-1:0]         limit_in;
    logic                  flush_in;
    logic [VALUE_BITS-1:0] head_value_in;
    logic [KEY_BITS-1:0]   head_key_in;
    logic [CW-1:0]         len_in;
    logic                  dequeue_out;
    logic [CW-1:0]         issued_count_out;
    logic                  busy_out;
    logic                  done_out;
    reader_state_t         state_out;

    sorted_move_reader_if #(.KEY_BITS(KEY_BITS), .VALUE_BITS(VALUE_BITS)) bus ();

    sorted_move_reader #(.MAX_LEN(MAX_LEN), .KEY_BITS(KEY_BITS), .VALUE_BITS(VALUE_BITS)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .limit_in         (limit_in),
        .flush_in         (flush_in),
        .head_value_in    (head_value_in),
        .head_key_in      (head_key_in),
        .len_in           (len_in),
        .dequeue_out      (dequeue_out),
        .out_if           (bus),
        .issued_count_out (issued_count_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .state_out        (state_out)
    );

    // ---------------- clock ----------------
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // ---------------- bookkeeping ----------------
    logic [KEY_BITS-1:0]   buf_key[$];
    logic [VALUE_BITS-1:0] buf_val[$];
    logic [W-1:0]          exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int deq_cnt = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int acc_base = 0;
    int ready_mode = 0;
    int bp_left = 5;
    logic                  deq_s;
    logic                  hold_pending = 1'b0;
    logic [KEY_BITS-1:0]   hold_key;
    logic [VALUE_BITS-1:0] hold_val;
    logic                  mon_ready;
    logic                  mon_acc;
    logic [W-1:0]          mon_exp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic update_ports();
        len_in = CW'(buf_key.size());
        if (buf_key.size() > 0) begin
            head_key_in   = buf_key[0];
            head_value_in = buf_val[0];
        end else begin
            head_key_in   = '0;
            head_value_in = '0;
        end
    endtask

    // Buffer model: descending keys, equal keys keep insertion order.
    task automatic insert(input logic [KEY_BITS-1:0] k, input logic [VALUE_BITS-1:0] v);
        int idx;
        idx = buf_key.size();
        check("insert_while_busy", busy_out, 0);
        for (int i = buf_key.size() - 1; i >= 0; i--) begin
            if (buf_key[i] < k) idx = i;
        end
        buf_key.insert(idx, k);
        buf_val.insert(idx, v);
        update_ports();
    endtask

    task automatic clear_buffer();
        buf_key.delete();
        buf_val.delete();
        update_ports();
    endtask

    task automatic load_random(input int n);
        clear_buffer();
        for (int i = 0; i < n; i++)
            insert(KEY_BITS'($urandom_range(0, 255)), VALUE_BITS'($urandom_range(0, 32767)));
    endtask

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({buf_key[i], buf_val[i], (i == n - 1) ? 1'b1 : 1'b0});
    endtask

    task automatic pulse_start(input int lim);
        limit_in = CW'(lim);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        limit_in = CW'($urandom_range(1, MAX_LEN));
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy_out && t < 500) begin
            step();
            t++;
        end
        check(name, busy_out, 0);
    endtask

    task automatic run_drain(input int lim, input int mode);
        int len0, n, deq0, done0, acc0;
        len0 = buf_key.size();
        n = (lim == 0 || lim > len0) ? len0 : lim;
        push_expected(n);
        deq0 = deq_cnt; done0 = done_cnt; acc0 = acc_cnt;
        acc_base = acc_cnt;
        ready_mode = mode;
        pulse_start(lim);
        check("count_cleared", issued_count_out, 0);
        check("done_after_start", done_out, (len0 == 0) ? 1 : 0);
        wait_idle("drain_timeout");
        check("exp_drained", exp_q.size(), 0);
        check("issued_count", issued_count_out, n);
        check("done_pulses", done_cnt - done0, 1);
        check("dequeues", deq_cnt - deq0, n);
        check("accepts", acc_cnt - acc0, n);
        check("len_after", len_in, len0 - n);
        exp_q.delete();
        ready_mode = 0;
    endtask

    // ---------------- buffer: pops on each dequeue strobe ----------------
    always begin
        @(negedge clk_in);
        deq_s = dequeue_out;
        @(posedge clk_in);
        #1;
        if (deq_s && rst_in) begin
            deq_cnt++;
            check("dequeue_nonempty", (buf_key.size() > 0) ? 1 : 0, 1);
            if (buf_key.size() > 0) begin
                void'(buf_key.pop_front());
                void'(buf_val.pop_front());
            end
            update_ports();
        end
    end

    // ---------------- monitor: drives ready, checks transfers ----------------
    always @(negedge clk_in) begin
        if (done_out) done_cnt++;
        if (hold_pending && rst_in) begin
            check("hold_valid", bus.valid, 1);
            check("hold_key", bus.key, hold_key);
            check("hold_value", bus.value, hold_val);
        end
        if (acc_cnt == acc_base) bp_left = 5;
        case (ready_mode)
            1: mon_ready = ($urandom_range(0, 1) == 1);
            2: begin
                mon_ready = 1'b1;
                if (bus.valid && (acc_cnt - acc_base == 1) && bp_left > 0) begin
                    mon_ready = 1'b0;
                    bp_left--;
                end
            end
            3: mon_ready = 1'b0;
            default: mon_ready = 1'b1;
        endcase
        bus.ready    = mon_ready;
        mon_acc      = rst_in && bus.valid && mon_ready && !flush_in;
        hold_pending = rst_in && bus.valid && !mon_ready && !flush_in;
        hold_key     = bus.key;
        hold_val     = bus.value;
        if (mon_acc) begin
            acc_cnt++;
            check("entry_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("key", bus.key, mon_exp[W-1 -: KEY_BITS]);
                check("value", bus.value, mon_exp[VALUE_BITS:1]);
                check("last", bus.last, mon_exp[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t, deq0, done0, acc0;
        rst_in = 1'b0; start_in = 1'b0; flush_in = 1'b0; limit_in = '0;
        update_ports();
        #1;
        check("rst_valid", bus.valid, 0);
        check("rst_dequeue", dequeue_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_count", issued_count_out, 0);
        step(); step();
        rst_in = 1'b1;
        step();

        // full drain of a known buffer
        clear_buffer();
        insert(8'd40, 15'd1000); insert(8'd7, 15'd2000); insert(8'd90, 15'd3000); insert(8'd12, 15'd4000);
        check("order_model", buf_key[0], 90);
        run_drain(0, 0);

        // top-N
        load_random(10);
        run_drain(3, 0);

        // backpressure on the second entry
        load_random(5);
        run_drain(0, 2);

        // empty start
        clear_buffer();
        run_drain(0, 0);

        // flush after the second accept
        load_random(6);
        push_expected(6);
        deq0 = deq_cnt; done0 = done_cnt; acc0 = acc_cnt; acc_base = acc_cnt; ready_mode = 0;
        pulse_start(0);
        t = 0;
        while (acc_cnt - acc0 < 2 && t < 100) begin step(); t++; end
        check("flush_wait", acc_cnt - acc0, 2);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("valid_after_flush", bus.valid, 0);
        wait_idle("flush_timeout");
        check("flush_state", state_out, ST_IDLE);
        check("flush_dequeues", deq_cnt - deq0, 6);
        check("flush_len", len_in, 0);
        check("flush_no_done", done_cnt - done0, 0);
        check("flush_accepts", acc_cnt - acc0, 2);
        check("flush_count", issued_count_out, 2);
        check("flush_leftover", exp_q.size(), 4);
        exp_q.delete();

        // flush while an entry is presented and stalled
        load_random(5);
        push_expected(5);
        deq0 = deq_cnt; done0 = done_cnt; acc0 = acc_cnt; acc_base = acc_cnt; ready_mode = 3;
        pulse_start(0);
        t = 0;
        while (!bus.valid && t < 50) begin step(); t++; end
        check("stall_valid", bus.valid, 1);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("valid_drop_flush", bus.valid, 0);
        wait_idle("flush2_timeout");
        check("flush2_dequeues", deq_cnt - deq0, 5);
        check("flush2_len", len_in, 0);
        check("flush2_no_done", done_cnt - done0, 0);
        check("flush2_accepts", acc_cnt - acc0, 0);
        exp_q.delete();
        ready_mode = 0;

        // async reset while presenting the second entry
        load_random(6);
        push_expected(6);
        acc0 = acc_cnt; acc_base = acc_cnt; ready_mode = 0;
        pulse_start(0);
        t = 0;
        while (!(acc_cnt - acc0 >= 1 && bus.valid) && t < 50) begin step(); t++; end
        check("reset_wait", bus.valid, 1);
        rst_in = 1'b0;
        #1;
        check("arst_valid", bus.valid, 0);
        check("arst_last", bus.last, 0);
        check("arst_key", bus.key, 0);
        check("arst_value", bus.value, 0);
        check("arst_dequeue", dequeue_out, 0);
        check("arst_busy", busy_out, 0);
        check("arst_count", issued_count_out, 0);
        check("arst_state", state_out, ST_IDLE);
        exp_q.delete();
        step(); step();
        rst_in = 1'b1;
        step();
        check("len_kept_over_reset", len_in, 4);
        run_drain(0, 1);

        // randomized drains with random ready
        for (int i = 0; i < 6; i++) begin
            int n, lim;
            n = $urandom_range(1, 12);
            load_random(n);
            lim = $urandom_range(0, n + 2);
            run_drain(lim, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
